// File: rtl/intr_ctrl.sv
// Memory-mapped interrupt controller: edge capture, masking, fixed priority, req/ack/eret handshake.
// Define INTC_VECTOR_EN to give each source its own 8-byte vector slot above BASE_VEC.
module intr_ctrl #(
   parameter int unsigned NSRC      = 4,
   parameter logic [31:0] BASE_ADDR = 32'h4000_0030,
   parameter logic [31:0] BASE_VEC  = 32'h8000_0004
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] src,
   input  logic            bus_rd,
   input  logic            bus_wr,
   input  logic [31:0]     bus_addr,
   input  logic [31:0]     bus_wdata,
   output logic [31:0]     bus_rdata,
   input  logic            in_kernel,
   output logic            irq_req,
   input  logic            irq_ack,
   input  logic            eret,
   output logic [31:0]     irq_vector,
   output logic [2:0]      irq_id
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t          state_q, state_d;
   logic [NSRC-1:0] src_q, pend_q, mask_q, pend_d;
   logic [NSRC-1:0] w1c, sw_set, id_onehot, ack_clr;
   logic [2:0]      id_q, cand_id, off;
   logic [31:0]     vec_q;
   logic            reg_hit, wr_pend, wr_mask, wr_swtrig;
   logic            cand_vld, cur_live, take, do_ack;
   logic            unused_bits;

   // Word offset relative to BASE_ADDR inside the 32-byte decode window
   assign off       = bus_addr[4:2] - BASE_ADDR[4:2];
   assign reg_hit   = (bus_addr[31:5] == BASE_ADDR[31:5]) && !off[2];
   assign wr_pend   = bus_wr && reg_hit && (off[1:0] == 2'd0);
   assign wr_mask   = bus_wr && reg_hit && (off[1:0] == 2'd1);
   assign wr_swtrig = bus_wr && reg_hit && (off[1:0] == 2'd2);

   assign w1c    = wr_pend   ? bus_wdata[NSRC-1:0] : '0;
   assign sw_set = wr_swtrig ? bus_wdata[NSRC-1:0] : '0;

   assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:NSRC]};

   always_comb begin
      cand_vld = 1'b0;
      cand_id  = '0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (!cand_vld && pend_q[i] && mask_q[i]) begin
            cand_vld = 1'b1;
            cand_id  = 3'(i);
         end
      end
   end

   always_comb begin
      id_onehot = '0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         id_onehot[i] = (32'(id_q) == i);
      end
   end

   assign cur_live = |(pend_q & mask_q & id_onehot);

   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      do_ack  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cand_vld && !in_kernel) begin
               state_d = REQ;
               take    = 1'b1;
            end
         end
         REQ: begin
            if (irq_ack) begin
               state_d = SERVICE;
               do_ack  = 1'b1;
            end else if (in_kernel || !cur_live) begin
               state_d = IDLE;
            end
         end
         SERVICE: begin
            if (eret) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Sets are ORed in last so an edge or SWTRIG always wins over a same-cycle clear
   assign ack_clr = do_ack ? id_onehot : '0;
   assign pend_d  = (pend_q & ~(w1c | ack_clr)) | (src & ~src_q) | sw_set;

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         src_q  <= '0;
         pend_q <= '0;
         mask_q <= '0;
         id_q   <= '0;
         vec_q  <= BASE_VEC;
      end else begin
         src_q  <= src;
         pend_q <= pend_d;
         if (wr_mask) mask_q <= bus_wdata[NSRC-1:0];
         if (take) begin
            id_q <= cand_id;
`ifdef INTC_VECTOR_EN
            vec_q <= BASE_VEC + 32'({cand_id, 3'b000});
`else
            vec_q <= BASE_VEC;
`endif
         end
      end
   end

   always_comb begin
      bus_rdata = '0;
      if (bus_rd && reg_hit) begin
         case (off[1:0])
            2'd0:    bus_rdata[NSRC-1:0] = pend_q;
            2'd1:    bus_rdata[NSRC-1:0] = mask_q;
            2'd3:    bus_rdata[3:0]      = {state_q == SERVICE, id_q};
            default: bus_rdata           = '0;
         endcase
      end
   end

   assign irq_req    = (state_q == REQ);
   assign irq_id     = id_q;
   assign irq_vector = vec_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios plus randomized traffic against a cycle model.
module tb_intr_ctrl;

   localparam int          NSRC = 4;
   localparam logic [31:0] BASE = 32'h4000_0030;
   localparam logic [31:0] VEC  = 32'h8000_0004;

   logic            clk, reset;
   logic [NSRC-1:0] src;
   logic            bus_rd, bus_wr;
   logic [31:0]     bus_addr, bus_wdata, bus_rdata;
   logic            in_kernel, irq_req, irq_ack, eret;
   logic [31:0]     irq_vector;
   logic [2:0]      irq_id;

   int checks   = 0;
   int failures = 0;

   intr_ctrl #(.NSRC(NSRC), .BASE_ADDR(BASE), .BASE_VEC(VEC)) dut (
      .clk(clk), .reset(reset), .src(src),
      .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .in_kernel(in_kernel), .irq_req(irq_req), .irq_ack(irq_ack),
      .eret(eret), .irq_vector(irq_vector), .irq_id(irq_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: pending/mask as bit arrays, handshake as a phase number (0 idle, 1 request, 2 service)
   bit m_pend [NSRC];
   bit m_mask [NSRC];
   bit m_prev [NSRC];
   int m_phase;
   int m_cur;

   function automatic logic [31:0] exp_vec(input int id);
`ifdef INTC_VECTOR_EN
      return VEC + 32'(id * 8);
`else
      return VEC;
`endif
   endfunction

   function automatic int m_reg(input logic [31:0] a);
      int d;
      if (a[31:5] != BASE[31:5]) return -1;
      d = int'(a >> 2) - int'(BASE >> 2);
      if (d >= 0 && d <= 3) return d;
      return -1;
   endfunction

   function automatic logic [31:0] exp_rdata();
      logic [31:0] r;
      r = '0;
      if (bus_rd) begin
         case (m_reg(bus_addr))
            0: for (int i = 0; i < NSRC; i++) r[i] = m_pend[i];
            1: for (int i = 0; i < NSRC; i++) r[i] = m_mask[i];
            3: r = 32'(m_cur) + ((m_phase == 2) ? 32'd8 : 32'd0);
            default: r = '0;
         endcase
      end
      return r;
   endfunction

   task automatic model_step();
      int  cand, rg;
      bit  np [NSRC];
      bit  set, clr;
      if (reset) begin
         for (int i = 0; i < NSRC; i++) begin
            m_pend[i] = 0; m_mask[i] = 0; m_prev[i] = 0;
         end
         m_phase = 0;
         m_cur   = 0;
         return;
      end
      cand = -1;
      for (int i = 0; i < NSRC; i++) if (cand < 0 && m_pend[i] && m_mask[i]) cand = i;
      rg = m_reg(bus_addr);
      for (int i = 0; i < NSRC; i++) begin
         set = (src[i] && !m_prev[i]) || (bus_wr && rg == 2 && bus_wdata[i]);
         clr = (bus_wr && rg == 0 && bus_wdata[i]) || (m_phase == 1 && irq_ack && m_cur == i);
         np[i] = set ? 1'b1 : (clr ? 1'b0 : m_pend[i]);
      end
      case (m_phase)
         0: if (cand >= 0 && !in_kernel) begin m_phase = 1; m_cur = cand; end
         1: if (irq_ack) m_phase = 2;
            else if (in_kernel || !(m_pend[m_cur] && m_mask[m_cur])) m_phase = 0;
         default: if (eret) m_phase = 0;
      endcase
      for (int i = 0; i < NSRC; i++) begin
         m_pend[i] = np[i];
         if (bus_wr && rg == 1) m_mask[i] = bus_wdata[i];
         m_prev[i] = src[i];
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         model_step();
         #1;
      end
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] d);
      bus_wr = 1'b1; bus_addr = BASE + off; bus_wdata = d;
      step(1);
      bus_wr = 1'b0; bus_addr = '0; bus_wdata = '0;
   endtask

   task automatic rd(input logic [31:0] off, output logic [31:0] d);
      bus_rd = 1'b1; bus_addr = BASE + off;
      #1;
      d = bus_rdata;
      bus_rd = 1'b0; bus_addr = '0;
   endtask

   task automatic pulse_ack_eret();
      irq_ack = 1'b1; step(1); irq_ack = 1'b0;
      eret = 1'b1; step(1); eret = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b1; step(2); reset = 1'b0;
      checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", irq_req); end
      checks++; if (irq_id !== 3'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", irq_id); end
      checks++; if (irq_vector !== VEC) begin failures++; $display("FAIL reset_vec got=%h exp=%h", irq_vector, VEC); end
      bus_addr = BASE; #1;
      checks++; if (bus_rdata !== 32'd0) begin failures++; $display("FAIL rdata_no_rd got=%h exp=0", bus_rdata); end
      bus_addr = '0;
      rd(32'h0, d); checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_pend got=%h exp=0", d); end
      rd(32'h4, d); checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_mask got=%h exp=0", d); end
      rd(32'hC, d); checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_stat got=%h exp=0", d); end
   endtask

   task automatic test_edge_latency();
      logic [31:0] d;
      wr(32'h4, 32'h3);
      src = 4'b0010; step(1);
      checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL edge_n1_req got=%0b exp=0", irq_req); end
      rd(32'h0, d); checks++; if (d !== 32'h2) begin failures++; $display("FAIL edge_n1_pend got=%h exp=2", d); end
      src = 4'b0000; step(1);
      checks++; if (irq_req !== 1'b1) begin failures++; $display("FAIL edge_n2_req got=%0b exp=1", irq_req); end
      checks++; if (irq_id !== 3'd1) begin failures++; $display("FAIL edge_id got=%0d exp=1", irq_id); end
      checks++; if (irq_vector !== exp_vec(1)) begin failures++; $display("FAIL edge_vec got=%h exp=%h", irq_vector, exp_vec(1)); end
      irq_ack = 1'b1; step(1); irq_ack = 1'b0;
      checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL ack_req got=%0b exp=0", irq_req); end
      rd(32'hC, d); checks++; if (d !== 32'h9) begin failures++; $display("FAIL svc_stat got=%h exp=9", d); end
      rd(32'h0, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL ack_pend got=%h exp=0", d); end
      step(2);
      checks++; if (irq_vector !== exp_vec(1)) begin failures++; $display("FAIL svc_vec_hold got=%h exp=%h", irq_vector, exp_vec(1)); end
      eret = 1'b1; step(1); eret = 1'b0;
      rd(32'hC, d); checks++; if (d !== 32'h1) begin failures++; $display("FAIL eret_stat got=%h exp=1", d); end
      step(1);
      checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL post_eret_req got=%0b exp=0", irq_req); end
   endtask

   task automatic test_priority();
      logic [31:0] d;
      src = 4'b0011; step(1); src = 4'b0000; step(1);
      checks++; if (irq_req !== 1'b1 || irq_id !== 3'd0) begin failures++; $display("FAIL prio_first got=req%0b id%0d exp=req1 id0", irq_req, irq_id); end
      irq_ack = 1'b1; step(1); irq_ack = 1'b0;
      rd(32'h0, d); checks++; if (d !== 32'h2) begin failures++; $display("FAIL prio_pend got=%h exp=2", d); end
      eret = 1'b1; step(1); eret = 1'b0;
      checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL prio_m1_req got=%0b exp=0", irq_req); end
      step(1);
      checks++; if (irq_req !== 1'b1 || irq_id !== 3'd1) begin failures++; $display("FAIL prio_second got=req%0b id%0d exp=req1 id1", irq_req, irq_id); end
      checks++; if (irq_vector !== exp_vec(1)) begin failures++; $display("FAIL prio_vec got=%h exp=%h", irq_vector, exp_vec(1)); end
      pulse_ack_eret(); step(2);
   endtask

   task automatic test_mask();
      logic [31:0] d;
      wr(32'h4, 32'h0);
      src = 4'b0100; step(1); src = 4'b0000; step(2);
      checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL masked_req got=%0b exp=0", irq_req); end
      rd(32'h0, d); checks++; if (d !== 32'h4) begin failures++; $display("FAIL masked_pend got=%h exp=4", d); end
      wr(32'h0, 32'h4);
      rd(32'h0, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL w1c_pend got=%h exp=0", d); end
      src = 4'b0100; step(1); src = 4'b0000; step(1);
      wr(32'h4, 32'h4);
      checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL unmask_w1_req got=%0b exp=0", irq_req); end
      step(1);
      checks++; if (irq_req !== 1'b1 || irq_id !== 3'd2) begin failures++; $display("FAIL unmask_req got=req%0b id%0d exp=req1 id2", irq_req, irq_id); end
      pulse_ack_eret(); step(1);
   endtask

   task automatic test_kernel_abort();
      logic [31:0] d;
      bit got;
      wr(32'h4, 32'hF);
      src = 4'b1000; step(1); src = 4'b0000; step(1);
      checks++; if (irq_req !== 1'b1 || irq_id !== 3'd3) begin failures++; $display("FAIL kern_req got=req%0b id%0d exp=req1 id3", irq_req, irq_id); end
      in_kernel = 1'b1; step(1);
      checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL kern_drop got=%0b exp=0", irq_req); end
      rd(32'h0, d); checks++; if (d !== 32'h8) begin failures++; $display("FAIL kern_pend got=%h exp=8", d); end
      step(1);
      checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL kern_hold got=%0b exp=0", irq_req); end
      in_kernel = 1'b0;
      got = 0;
      for (int k = 0; k < 2 && !got; k++) begin
         step(1);
         if (irq_req === 1'b1) got = 1;
      end
      checks++; if (!got || irq_id !== 3'd3) begin failures++; $display("FAIL kern_rereq got=req%0b id%0d exp=req1 id3", got, irq_id); end
      pulse_ack_eret(); step(1);
   endtask

   task automatic test_conflict_swtrig();
      logic [31:0] d;
      wr(32'h4, 32'h0);
      src = 4'b1000; step(1); src = 4'b0000; step(1);
      src = 4'b1000; bus_wr = 1'b1; bus_addr = BASE; bus_wdata = 32'h8;
      step(1);
      bus_wr = 1'b0; bus_addr = '0; bus_wdata = '0;
      rd(32'h0, d); checks++; if (d !== 32'h8) begin failures++; $display("FAIL set_beats_w1c got=%h exp=8", d); end
      src = 4'b0000; wr(32'h0, 32'h8);
      rd(32'h0, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL w1c3 got=%h exp=0", d); end
      wr(32'h4, 32'h1);
      wr(32'h8, 32'h1);
      checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL swtrig_n1_req got=%0b exp=0", irq_req); end
      rd(32'h0, d); checks++; if (d !== 32'h1) begin failures++; $display("FAIL swtrig_pend got=%h exp=1", d); end
      rd(32'h8, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL swtrig_read got=%h exp=0", d); end
      step(1);
      checks++; if (irq_req !== 1'b1 || irq_id !== 3'd0) begin failures++; $display("FAIL swtrig_req got=req%0b id%0d exp=req1 id0", irq_req, irq_id); end
      pulse_ack_eret(); step(1);
   endtask

   task automatic test_held_high();
      logic [31:0] d;
      src = 4'b0001; step(2);
      checks++; if (irq_req !== 1'b1) begin failures++; $display("FAIL held_req got=%0b exp=1", irq_req); end
      pulse_ack_eret(); step(3);
      checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL held_once got=%0b exp=0", irq_req); end
      rd(32'h0, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL held_pend got=%h exp=0", d); end
      src = 4'b0000; step(1); src = 4'b0001; step(2);
      checks++; if (irq_req !== 1'b1) begin failures++; $display("FAIL held_rerise got=%0b exp=1", irq_req); end
      src = 4'b0000;
      pulse_ack_eret(); step(1);
   endtask

   task automatic test_reset_service();
      logic [31:0] d;
      wr(32'h4, 32'hF);
      wr(32'h8, 32'h4); step(1);
      irq_ack = 1'b1; step(1); irq_ack = 1'b0;
      rd(32'hC, d); checks++; if (d !== 32'hA) begin failures++; $display("FAIL pre_reset_stat got=%h exp=a", d); end
      wr(32'h8, 32'h1);
      reset = 1'b1; step(1); reset = 1'b0;
      checks++; if (irq_req !== 1'b0 || irq_id !== 3'd0) begin failures++; $display("FAIL rst_svc_out got=req%0b id%0d exp=req0 id0", irq_req, irq_id); end
      checks++; if (irq_vector !== VEC) begin failures++; $display("FAIL rst_svc_vec got=%h exp=%h", irq_vector, VEC); end
      rd(32'h0, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_svc_pend got=%h exp=0", d); end
      rd(32'h4, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_svc_mask got=%h exp=0", d); end
      rd(32'hC, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_svc_stat got=%h exp=0", d); end
   endtask

   task automatic test_random();
      logic [31:0] addrs [6];
      logic [31:0] er;
      int op;
      addrs[0] = BASE;          addrs[1] = BASE + 32'h4;  addrs[2] = BASE + 32'h8;
      addrs[3] = BASE + 32'hC;  addrs[4] = 32'h4000_0020; addrs[5] = 32'h4000_0040;
      reset = 1'b1; step(1); reset = 1'b0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NSRC; i++) if ($urandom_range(7) == 0) src[i] = ~src[i];
         in_kernel = ($urandom_range(3) == 0);
         irq_ack   = ($urandom_range(2) == 0);
         eret      = ($urandom_range(4) == 0);
         reset     = ($urandom_range(99) == 0);
         op        = $urandom_range(9);
         bus_rd    = (op < 4);
         bus_wr    = (op >= 7);
         bus_addr  = addrs[$urandom_range(5)];
         bus_wdata = $urandom;
         #1;
         er = exp_rdata();
         checks++; if (irq_req !== (m_phase == 1)) begin failures++; $display("FAIL rnd_req c=%0d got=%0b exp=%0b", c, irq_req, m_phase == 1); end
         checks++; if (irq_id !== 3'(m_cur)) begin failures++; $display("FAIL rnd_id c=%0d got=%0d exp=%0d", c, irq_id, m_cur); end
         checks++; if (irq_vector !== exp_vec(m_cur)) begin failures++; $display("FAIL rnd_vec c=%0d got=%h exp=%h", c, irq_vector, exp_vec(m_cur)); end
         checks++; if (bus_rdata !== er) begin failures++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, bus_rdata, er); end
         step(1);
      end
      src = '0; in_kernel = 0; irq_ack = 0; eret = 0; reset = 0;
      bus_rd = 0; bus_wr = 0; bus_addr = '0; bus_wdata = '0;
      step(2);
   endtask

   initial begin
      reset = 1'b1; src = '0; bus_rd = 0; bus_wr = 0; bus_addr = '0; bus_wdata = '0;
      in_kernel = 0; irq_ack = 0; eret = 0;
      test_reset();
      test_edge_latency();
      test_priority();
      test_mask();
      test_kernel_abort();
      test_conflict_swtrig();
      test_held_high();
      test_reset_service();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
